// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch stage: issues sequential fetches into a small FIFO and flushes on redirect.
// Optional performance counters are enabled by defining IF_PREFETCH_PERF_EN.
module if_prefetch_stage #(
    parameter int PC_W     = 8,
    parameter int INSTR_W  = 32,
    parameter int DEPTH    = 4,
    parameter int PC_INC   = 4,
    parameter int RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [PC_W-1:0]            imem_addr,
    input  logic [INSTR_W-1:0]         imem_rdata,
    input  logic                       BranchTaken,
    input  logic [PC_W-1:0]            BranchTarget,
    input  logic                       ID_Ready,
    output logic                       IF_ID_Valid,
    output logic [INSTR_W-1:0]         IF_ID_Instruction,
    output logic [PC_W-1:0]            IF_ID_PC,
    output logic [$clog2(DEPTH):0]     q_count
`ifdef IF_PREFETCH_PERF_EN
    ,
    output logic [15:0]                perf_fetch_cnt,
    output logic [15:0]                perf_flush_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    tag_q, tag_d;
    logic               inflight_q, inflight_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PC_W-1:0]    pc_mem    [DEPTH];

    logic               deq_fire;
    logic               enq_fire;
    logic [OW-1:0]      occupancy;

    always_comb begin
        deq_fire  = (count_q != '0) && ID_Ready && !BranchTaken;
        // A response arriving in the redirect cycle belongs to the old path and is dropped.
        enq_fire  = inflight_q && !BranchTaken;
        // Occupancy counts the slot reserved by the outstanding response.
        occupancy = {1'b0, count_q} + OW'(inflight_q) - OW'(deq_fire);
        imem_req  = !rst && !BranchTaken && (occupancy < OW'(DEPTH));

        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = 1'b0;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (BranchTaken) begin
            pc_d     = BranchTarget;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_fire) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (deq_fire) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(enq_fire) - CW'(deq_fire);
            if (imem_req) begin
                pc_d  = pc_q + PC_W'(PC_INC);
                tag_d = pc_q;
            end
            inflight_d = imem_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= PC_W'(RESET_PC);
            tag_q      <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Payload storage carries no reset; validity is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            instr_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]    <= tag_q + PC_W'(PC_INC);
        end
    end

    assign imem_addr         = pc_q;
    assign q_count           = count_q;
    assign IF_ID_Valid       = (count_q != '0);
    assign IF_ID_Instruction = IF_ID_Valid ? instr_mem[rd_ptr_q] : '0;
    assign IF_ID_PC          = IF_ID_Valid ? pc_mem[rd_ptr_q] : '0;

`ifdef IF_PREFETCH_PERF_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [16:0] flush_sum;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        flush_sum   = {1'b0, flush_cnt_q} + 17'(count_q) + 17'(inflight_q);
        if (enq_fire && (fetch_cnt_q != 16'hFFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        end
        if (BranchTaken) begin
            flush_cnt_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
